// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared encodings for the two-port memory arbiter
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY_A = 2'd1;
   localparam logic [1:0] BUSY_B = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = IDLE,
      ST_BUSY_A = BUSY_A,
      ST_BUSY_B = BUSY_B,
      ST_DONE   = DONE
   } state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mux2_32.sv
// ============================================================================
// mux2_32 : 32-bit 2:1 datapath mux (0 selects d0, 1 selects d1)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mux2_32 #(
   parameter int WIDTH = 32
) (
   input  logic             i_sel,
   input  logic [WIDTH-1:0] i_d0,
   input  logic [WIDTH-1:0] i_d1,
   output logic [WIDTH-1:0] o_y
);

   assign o_y = i_sel ? i_d1 : i_d0;

endmodule

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// rr_pick2 : two-way grant pick; round-robin on ties unless
//            MEM_ARB_FIXED_PRIO_EN is defined (then B always wins a tie)
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic i_a_req,
   input  logic i_b_req,
   input  logic i_last_gnt,
   output logic o_gnt
);

`ifdef MEM_ARB_FIXED_PRIO_EN
   logic w_unused_last_gnt;
   assign w_unused_last_gnt = i_last_gnt;
`endif

   always_comb begin
      o_gnt = SEL_A;
      if (i_a_req && i_b_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         o_gnt = SEL_B;
`else
         o_gnt = (i_last_gnt == SEL_B) ? SEL_A : SEL_B;
`endif
      end else if (i_b_req) begin
         o_gnt = SEL_B;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one memory port between fetch (A) and LSU (B);
//                    optional fixed B priority via MEM_ARB_FIXED_PRIO_EN
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a_req,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   input  logic          a_we,
   output logic          a_done,
   input  logic          b_req,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   input  logic          b_we,
   output logic          b_done,
   output logic [DW-1:0] rdata,
   output logic          sel,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata
);

   state_t        state_q,    state_d;
   logic          mem_req_q,  mem_req_d;
   logic          sel_q,      sel_d;
   logic          a_done_q,   a_done_d;
   logic          b_done_q,   b_done_d;
   logic [DW-1:0] rdata_q,    rdata_d;
   logic          last_gnt_q, last_gnt_d;
   logic          w_gnt;

   rr_pick2 u_pick (
      .i_a_req    (a_req),
      .i_b_req    (b_req),
      .i_last_gnt (last_gnt_q),
      .o_gnt      (w_gnt)
   );

   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      sel_d      = sel_q;
      a_done_d   = 1'b0;
      b_done_d   = 1'b0;
      rdata_d    = rdata_q;
      last_gnt_d = last_gnt_q;
      case (state_q)
         ST_IDLE: begin
            if (a_req || b_req) begin
               sel_d     = w_gnt;
               mem_req_d = 1'b1;
               state_d   = (w_gnt == SEL_B) ? ST_BUSY_B : ST_BUSY_A;
            end
         end
         ST_BUSY_A, ST_BUSY_B: begin
            if (mem_ack) begin
               rdata_d    = mem_rdata;
               last_gnt_d = sel_q;
               mem_req_d  = 1'b0;
               a_done_d   = (sel_q == SEL_A);
               b_done_d   = (sel_q == SEL_B);
               state_d    = ST_DONE;
            end
         end
         // Requests are deliberately not looked at here so a requester
         // dropping req on its done cycle never sees a second grant.
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         mem_req_q  <= 1'b0;
         sel_q      <= SEL_A;
         a_done_q   <= 1'b0;
         b_done_q   <= 1'b0;
         rdata_q    <= '0;
         last_gnt_q <= SEL_B;
      end else begin
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         sel_q      <= sel_d;
         a_done_q   <= a_done_d;
         b_done_q   <= b_done_d;
         rdata_q    <= rdata_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   mux2_32 #(.WIDTH(AW)) u_addr_mux (
      .i_sel (sel_q),
      .i_d0  (a_addr),
      .i_d1  (b_addr),
      .o_y   (mem_addr)
   );

   mux2_32 #(.WIDTH(DW)) u_wdata_mux (
      .i_sel (sel_q),
      .i_d0  (a_wdata),
      .i_d1  (b_wdata),
      .o_y   (mem_wdata)
   );

   assign mem_we  = mem_req_q & ((sel_q == SEL_B) ? b_we : a_we);
   assign mem_req = mem_req_q;
   assign sel     = sel_q;
   assign a_done  = a_done_q;
   assign b_done  = b_done_q;
   assign rdata   = rdata_q;

endmodule

`default_nettype wire
